// File: rtl/fmap_window_scanner.sv
// Feature-map buffer that scans every KxK window at stride STRIDE in raster order
// and streams each one over a valid/ready port. It also has a registered single-pixel debug read.
module fmap_window_scanner #(
    parameter int DW     = 16,
    parameter int SIZE   = 5,
    parameter int K      = 4,
    parameter int STRIDE = 1,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_row,
    input  logic [AW-1:0]     wr_col,
    input  logic [DW-1:0]     data_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [AW-1:0]     win_row,
    output logic [AW-1:0]     win_col,
    output logic [K*K*DW-1:0] win_data,
    input  logic              dbg_rd_en,
    input  logic [AW-1:0]     dbg_row,
    input  logic [AW-1:0]     dbg_col,
    output logic [DW-1:0]     dbg_data
);

    localparam int          NPOS  = (SIZE - K) / STRIDE + 1;
    localparam logic [AW-1:0] LAST = AW'((NPOS - 1) * STRIDE);
    localparam logic [AW-1:0] STEP = AW'(STRIDE);
    localparam logic [AW:0]   LIM  = (AW+1)'(SIZE);
    localparam int          DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state;
    // Sized to the full address space so every index is exactly AW bits; rows/cols >= SIZE stay zero.
    logic [DW-1:0]       mem [DEPTH][DEPTH];
    logic [AW-1:0]       nxt_row;
    logic [AW-1:0]       nxt_col;
    logic [K*K*DW-1:0]   nxt_data;
    logic                handshake;
    logic                last_pos;
    logic                wr_ok;
    logic                rd_ok;

    always_comb begin
        handshake = win_valid && win_ready;
        last_pos  = (win_row == LAST) && (win_col == LAST);
        wr_ok     = wr_en && !busy && ({1'b0, wr_row} < LIM) && ({1'b0, wr_col} < LIM);
        rd_ok     = dbg_rd_en && ({1'b0, dbg_row} < LIM) && ({1'b0, dbg_col} < LIM);
        if (state == IDLE) begin
            nxt_row = '0;
            nxt_col = '0;
        end else if (win_col == LAST) begin
            nxt_row = win_row + STEP;
            nxt_col = '0;
        end else begin
            nxt_row = win_row;
            nxt_col = win_col + STEP;
        end
        // Row 0 / col 0 lands in the MSBs.
        nxt_data = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                nxt_data[(K*K-1-(i*K+j))*DW +: DW] = mem[nxt_row + AW'(i)][nxt_col + AW'(j)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem       <= '{default: '{default: '0}};
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            win_data  <= '0;
            dbg_data  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_row][wr_col] <= data_in;
            end
            dbg_data <= rd_ok ? mem[dbg_row][dbg_col] : '0;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SCAN;
                        busy      <= 1'b1;
                        win_valid <= 1'b1;
                        win_row   <= nxt_row;
                        win_col   <= nxt_col;
                        win_data  <= nxt_data;
                    end
                end
                SCAN: begin
                    if (handshake) begin
                        if (last_pos) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            win_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            win_row  <= nxt_row;
                            win_col  <= nxt_col;
                            win_data <= nxt_data;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
